// File: rtl/corr_peak_trigger_if.sv
// Bus between the correlator sum stage, the peak trigger and its report consumer.
// master = correlator/consumer side, slave = corr_peak_trigger.
interface corr_peak_trigger_if;
    logic        corr_valid;
    logic [10:0] corr0;
    logic [10:0] corr1;
    logic [10:0] corr2;
    logic [10:0] corr3;
    logic [10:0] threshold;
    logic        enable;
    logic        trig_ack;
    logic        trig_valid;
    logic [10:0] peak_value;
    logic [1:0]  peak_index;
    logic [7:0]  peak_cycle;
    logic        busy;
    logic [15:0] missed_count;

    modport master (
        output corr_valid, corr0, corr1, corr2, corr3, threshold, enable, trig_ack,
        input  trig_valid, peak_value, peak_index, peak_cycle, busy, missed_count
    );

    modport slave (
        input  corr_valid, corr0, corr1, corr2, corr3, threshold, enable, trig_ack,
        output trig_valid, peak_value, peak_index, peak_cycle, busy, missed_count
    );
endinterface

// File: rtl/corr_peak_trigger.sv
// Threshold trigger with windowed peak search over four correlator outputs.
// Optional missed-crossing counter is built when CORR_PEAK_MISSED_COUNT_EN is defined.
module corr_peak_trigger #(
    parameter int WINDOW_LEN  = 8,
    parameter int HOLDOFF_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    corr_peak_trigger_if.slave bus
);
    typedef enum logic [1:0] {ARMED, WINDOW, REPORT, HOLDOFF} state_t;

    localparam logic [7:0]  WIN_INIT  = 8'(WINDOW_LEN - 1);
    localparam logic [15:0] HOLD_INIT = 16'(HOLDOFF_LEN - 1);

    logic             s_valid_q;
    logic [3:0][10:0] s_corr_q;

    state_t      state_q;
    logic        trig_valid_q;
    logic        busy_q;
    logic [10:0] peak_value_q;
    logic [1:0]  peak_index_q;
    logic [7:0]  peak_cycle_q;
    logic [7:0]  offset_q;
    logic [7:0]  win_cnt_q;
    logic [15:0] hold_cnt_q;

    logic [10:0] max_val_d;
    logic [1:0]  max_idx_d;
    logic        crossing_d;

    // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q <= 1'b0;
            s_corr_q  <= '0;
        end else begin
            s_valid_q <= bus.corr_valid;
            s_corr_q  <= {bus.corr3, bus.corr2, bus.corr1, bus.corr0};
        end
    end

    // NOTE: defaults assigned first so no path through the block leaves a value held, which would infer a latch.
    always_comb begin
        max_val_d = s_corr_q[0];
        max_idx_d = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (s_corr_q[i] > max_val_d) begin
                max_val_d = s_corr_q[i];
                max_idx_d = 2'(i);
            end
        end
    end

    assign crossing_d = s_valid_q && (max_val_d >= bus.threshold);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARMED;
            trig_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            peak_value_q <= '0;
            peak_index_q <= '0;
            peak_cycle_q <= '0;
            offset_q     <= '0;
            win_cnt_q    <= '0;
            hold_cnt_q   <= '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (bus.enable && crossing_d) begin
                        peak_value_q <= max_val_d;
                        peak_index_q <= max_idx_d;
                        peak_cycle_q <= 8'd0;
                        offset_q     <= 8'd0;
                        win_cnt_q    <= WIN_INIT;
                        busy_q       <= 1'b1;
                        if (WINDOW_LEN == 1) begin
                            state_q      <= REPORT;
                            trig_valid_q <= 1'b1;
                        end else begin
                            state_q <= WINDOW;
                        end
                    end
                end
                WINDOW: begin
                    if (!bus.enable) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b0;
                    end else if (s_valid_q) begin
                        offset_q  <= offset_q + 8'd1;
                        win_cnt_q <= win_cnt_q - 8'd1;
                        // Strictly greater: an equal later sample never displaces the earlier peak.
                        if (max_val_d > peak_value_q) begin
                            peak_value_q <= max_val_d;
                            peak_index_q <= max_idx_d;
                            peak_cycle_q <= offset_q + 8'd1;
                        end
                        if (win_cnt_q == 8'd1) begin
                            state_q      <= REPORT;
                            trig_valid_q <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (bus.trig_ack) begin
                        trig_valid_q <= 1'b0;
                        hold_cnt_q   <= HOLD_INIT;
                        if (HOLDOFF_LEN == 0) begin
                            state_q <= ARMED;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt_q == 16'd0) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= ARMED;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trig_valid = trig_valid_q;
    assign bus.peak_value = peak_value_q;
    assign bus.peak_index = peak_index_q;
    assign bus.peak_cycle = peak_cycle_q;
    assign bus.busy       = busy_q;

`ifdef CORR_PEAK_MISSED_COUNT_EN
    logic [15:0] missed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            missed_q <= '0;
        end else if (crossing_d && (state_q == REPORT || state_q == HOLDOFF)
                     && missed_q != 16'hFFFF) begin
            missed_q <= missed_q + 16'd1;
        end
    end

    assign bus.missed_count = missed_q;
`else
    assign bus.missed_count = 16'h0000;
`endif
endmodule
